// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/decode boundary bundle for the IF/ID stage
//
// Groups everything the fetch stage exchanges with instruction memory,
// hazard logic and decode.
//   imem_addr     fetch address (driven by the stage, equals the pc register)
//   imem_instr    instruction for imem_addr, returned in the same cycle
//   stall         hold PC and IF/ID this cycle
//   redirect      branch taken in decode this cycle
//   redirect_addr branch target
//   id_valid      IF/ID holds a real instruction
//   id_instr      latched instruction
//   id_pc         address of id_instr
//   id_pc_plus4   id_pc + 4, link value for BL
//   fetch_count   instructions latched valid since reset
//   stall_count   stalled cycles since reset
// Modports: slave = the fetch stage, master = its environment.
interface if_id_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic [ADDR_W-1:0]  id_pc_plus4;
    logic [31:0]        fetch_count;
    logic [31:0]        stall_count;

    modport slave (
        input  imem_instr, stall, redirect, redirect_addr,
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               fetch_count, stall_count
    );

    modport master (
        output imem_instr, stall, redirect, redirect_addr,
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               fetch_count, stall_count
    );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - LEGv8 instruction fetch stage and IF/ID pipeline register
//
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  synchronous active-high reset, highest priority
//   bus    if_id_stage_if.slave: imem address/instruction, stall/redirect
//          from hazard logic and decode, IF/ID outputs and event counters
//
// Branches use a single delay slot: the instruction fetched in the cycle a
// redirect is seen is still latched into IF/ID; only the next PC changes.
module if_id_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    if_id_stage_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0]  pcReg;
    logic [ADDR_W-1:0]  pcPlus4;
    logic               idValid;
    logic [INSTR_W-1:0] idInstr;
    logic [ADDR_W-1:0]  idPc;
    logic [ADDR_W-1:0]  idPcPlus4;
    logic [31:0]        fetchCount;
    logic [31:0]        stallCount;

    // Wraps modulo 2^ADDR_W by construction; no overflow flag is wanted.
    assign pcPlus4 = pcReg + PC_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg      <= RESET_PC;
            idValid    <= 1'b0;
            idInstr    <= '0;
            idPc       <= '0;
            idPcPlus4  <= '0;
            fetchCount <= '0;
            stallCount <= '0;
        end else if (bus.stall) begin
            // Stall wins over redirect: decode holds the branch and will
            // present it again once the stall clears.
            stallCount <= stallCount + 32'd1;
        end else begin
            idValid    <= 1'b1;
            idInstr    <= bus.imem_instr;
            idPc       <= pcReg;
            idPcPlus4  <= pcPlus4;
            fetchCount <= fetchCount + 32'd1;
            pcReg      <= bus.redirect ? bus.redirect_addr : pcPlus4;
        end
    end

    // Fetch address comes straight from the register so stall/redirect
    // never reach instruction memory combinationally.
    assign bus.imem_addr   = pcReg;
    assign bus.id_valid    = idValid;
    assign bus.id_instr    = idInstr;
    assign bus.id_pc       = idPc;
    assign bus.id_pc_plus4 = idPcPlus4;
    assign bus.fetch_count = fetchCount;
    assign bus.stall_count = stallCount;
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vector bench for if_id_stage
module tb_if_id_stage;
    logic clk;
    logic reset;

    if_id_stage_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    if_id_stage #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrAt(input logic [63:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    assign bus.imem_instr = instrAt(bus.imem_addr);

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [63:0] raddr;
        logic        expValid;
        logic [63:0] expPc;
        logic [63:0] expAddr;
        logic [31:0] expFc;
        logic [31:0] expSc;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic addVec(input logic rst, input logic stl, input logic rdr,
                          input logic [63:0] raddr, input logic expValid,
                          input logic [63:0] expPc, input logic [63:0] expAddr,
                          input logic [31:0] expFc, input logic [31:0] expSc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.raddr = raddr;
        v.expValid = expValid; v.expPc = expPc; v.expAddr = expAddr;
        v.expFc = expFc; v.expSc = expSc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic checkState(input int idx, input logic expValid,
                              input logic [63:0] expPc, input logic [63:0] expAddr,
                              input logic [31:0] expFc, input logic [31:0] expSc);
        logic [63:0] expPlus4;
        logic [31:0] expInstr;
        expPlus4 = expValid ? expPc + 64'd4 : 64'd0;
        expInstr = expValid ? instrAt(expPc) : 32'd0;
        vectors++;
        check("id_valid",    idx, {63'd0, bus.id_valid}, {63'd0, expValid});
        check("id_pc",       idx, bus.id_pc, expValid ? expPc : 64'd0);
        check("id_pc_plus4", idx, bus.id_pc_plus4, expPlus4);
        check("id_instr",    idx, {32'd0, bus.id_instr}, {32'd0, expInstr});
        check("imem_addr",   idx, bus.imem_addr, expAddr);
        check("fetch_count", idx, {32'd0, bus.fetch_count}, {32'd0, expFc});
        check("stall_count", idx, {32'd0, bus.stall_count}, {32'd0, expSc});
    endtask

    initial begin
        logic [63:0] heldAddr;

        // rst stl rdr raddr | valid id_pc imem_addr fetch stall
        // free run from reset
        addVec(1, 0, 0, 64'h0,   0, 64'h0,  64'h0,  0, 0);
        addVec(1, 0, 0, 64'h0,   0, 64'h0,  64'h0,  0, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h0,  64'h4,  1, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h4,  64'h8,  2, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h8,  64'hC,  3, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'hC,  64'h10, 4, 0);
        // redirect at pc=8 to 0x40: delay slot 8 then 0x40, 0x44
        addVec(1, 0, 0, 64'h0,   0, 64'h0,  64'h0,  0, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h0,  64'h4,  1, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h4,  64'h8,  2, 0);
        addVec(0, 0, 1, 64'h40,  1, 64'h8,  64'h40, 3, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h40, 64'h44, 4, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h44, 64'h48, 5, 0);
        // stall 3 cycles while id_pc=12
        addVec(1, 0, 0, 64'h0,   0, 64'h0,  64'h0,  0, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h0,  64'h4,  1, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h4,  64'h8,  2, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h8,  64'hC,  3, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'hC,  64'h10, 4, 0);
        addVec(0, 1, 0, 64'h0,   1, 64'hC,  64'h10, 4, 1);
        addVec(0, 1, 0, 64'h0,   1, 64'hC,  64'h10, 4, 2);
        addVec(0, 1, 0, 64'h0,   1, 64'hC,  64'h10, 4, 3);
        addVec(0, 0, 0, 64'h0,   1, 64'h10, 64'h14, 5, 3);
        // stall+redirect ignored, redirect next cycle takes effect
        addVec(0, 1, 1, 64'h100, 1, 64'h10, 64'h14,  5, 4);
        addVec(0, 0, 1, 64'h100, 1, 64'h14, 64'h100, 6, 4);
        addVec(0, 0, 0, 64'h0,   1, 64'h100, 64'h104, 7, 4);
        // wrap past the top of the address space
        addVec(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'h104, 64'hFFFF_FFFF_FFFF_FFF8, 8, 4);
        addVec(0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 9, 4);
        addVec(0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 10, 4);
        addVec(0, 0, 0, 64'h0, 1, 64'h0, 64'h4, 11, 4);
        // reset mid-stream with a pending redirect
        addVec(1, 0, 1, 64'h200, 0, 64'h0, 64'h0, 0, 0);
        addVec(0, 0, 0, 64'h0,   1, 64'h0, 64'h4, 1, 0);

        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = 64'h0;

        foreach (vecs[i]) begin
            reset             = vecs[i].rst;
            bus.stall         = vecs[i].stl;
            bus.redirect      = vecs[i].rdr;
            bus.redirect_addr = vecs[i].raddr;
            @(posedge clk);
            #1;
            checkState(i, vecs[i].expValid, vecs[i].expPc, vecs[i].expAddr,
                       vecs[i].expFc, vecs[i].expSc);
        end

        // imem_addr must not react combinationally to stall/redirect
        // (state here: pc=4, id_pc=0, fetch=1, stall=0)
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        #1;
        heldAddr = 64'h4;
        bus.redirect = 1'b1;
        bus.redirect_addr = 64'h999;
        #1;
        vectors++;
        check("comb_redirect", -1, bus.imem_addr, heldAddr);
        bus.stall = 1'b1;
        #1;
        vectors++;
        check("comb_stall", -1, bus.imem_addr, heldAddr);
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        @(posedge clk);
        #1;
        checkState(100, 1'b1, 64'h4, 64'h8, 32'd2, 32'd0);

        // a stall after a redirect edge keeps the redirected target on imem_addr
        bus.redirect = 1'b1;
        bus.redirect_addr = 64'h3000;
        @(posedge clk);
        #1;
        checkState(101, 1'b1, 64'h8, 64'h3000, 32'd3, 32'd0);
        bus.redirect = 1'b0;
        bus.stall = 1'b1;
        @(posedge clk);
        #1;
        checkState(102, 1'b1, 64'h8, 64'h3000, 32'd3, 32'd1);
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        checkState(103, 1'b1, 64'h3000, 64'h3004, 32'd4, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
